// File: rtl/register_dump_reader_pkg.sv
// Shared definitions for the register dump reader and the host-side frame decoder.
package register_dump_reader_pkg;

  localparam int          RDR_NUM_REGS     = 32;
  localparam int          RDR_ADDR_WIDTH   = 5;
  localparam int          RDR_DATA_WIDTH   = 32;
  localparam int          RDR_READ_LATENCY = 1;
  localparam logic [7:0]  RDR_SYNC_BYTE    = 8'hA5;

  // Bytes per frame: sync byte, every register word, checksum byte.
  `define RDR_FRAME_LEN(n, w) (2 + (n) * (w) / 8)

  localparam int RDR_FRAME_BYTES = `RDR_FRAME_LEN(RDR_NUM_REGS, RDR_DATA_WIDTH);

  typedef enum logic [2:0] {
    RDR_IDLE,
    RDR_SYNC,
    RDR_ADDR,
    RDR_WAIT,
    RDR_SEND,
    RDR_CSUM,
    RDR_DONE
  } rdr_state_t;

endpackage

// File: rtl/register_dump_reader_if.sv
// Debug read port plus outgoing byte channel of the dump reader.
interface register_dump_reader_if
  import register_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = RDR_ADDR_WIDTH,
  parameter int DATA_WIDTH = RDR_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] read_address_debug;
  logic [DATA_WIDTH-1:0] data_out_debug;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Reader side: drives the debug address and the byte stream.
  modport master (
    output read_address_debug, tx_data, tx_valid,
    input  data_out_debug, tx_ready
  );

  // Register file / byte sink side.
  modport slave (
    input  read_address_debug, tx_data, tx_valid,
    output data_out_debug, tx_ready
  );
endinterface

// File: rtl/register_dump_reader_word_byte_serializer.sv
// Snapshots one register word and hands it out MSB byte first under valid/ready.
module word_byte_serializer
  import register_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = RDR_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  output logic                  byte_last,
  input  logic                  byte_ready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bcnt;
  logic                  vld;

  assign byte_data  = shreg[DATA_WIDTH-1 -: 8];
  assign byte_valid = vld;
  assign byte_last  = (bcnt == CW'(NB - 1));

  // Load a fresh snapshot, then shift one byte out per accepted transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
      bcnt  <= '0;
      vld   <= 1'b0;
    end else if (load) begin
      shreg <= word;
      bcnt  <= '0;
      vld   <= 1'b1;
    end else if (vld && byte_ready) begin
      if (byte_last) begin
        vld <= 1'b0;
      end else begin
        shreg <= shreg << 8;
        bcnt  <= bcnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/register_dump_reader.sv
// Walks the register file debug port and streams a framed, checksummed dump as bytes.
module register_dump_reader
  import register_dump_reader_pkg::*;
#(
  parameter int         NUM_REGS     = RDR_NUM_REGS,
  parameter int         ADDR_WIDTH   = RDR_ADDR_WIDTH,
  parameter int         DATA_WIDTH   = RDR_DATA_WIDTH,
  parameter int         READ_LATENCY = RDR_READ_LATENCY,
  parameter logic [7:0] SYNC_BYTE    = RDR_SYNC_BYTE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dump_start,
  output logic                   dump_busy,
  output logic                   dump_done,
  register_dump_reader_if.master dbg
);
  rdr_state_t            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            wcnt;
  logic [7:0]            csum;
  logic [7:0]            hdr_data;   // sync / checksum byte
  logic                  hdr_valid;

  logic       ser_load, ser_valid, ser_last, ser_ready;
  logic [7:0] ser_byte;

  // Sync and checksum bytes come from hdr_*, word bytes from the serializer;
  // the two valids are never high together.
  assign dbg.tx_valid           = hdr_valid | ser_valid;
  assign dbg.tx_data            = ser_valid ? ser_byte : hdr_data;
  assign dbg.read_address_debug = addr_q;

  assign ser_load  = (state == RDR_WAIT) && (wcnt == 2'd0);
  assign ser_ready = (state == RDR_SEND) && dbg.tx_ready;

  word_byte_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clock      (clock),
    .reset      (reset),
    .load       (ser_load),
    .word       (dbg.data_out_debug),
    .byte_data  (ser_byte),
    .byte_valid (ser_valid),
    .byte_last  (ser_last),
    .byte_ready (ser_ready)
  );

  // Frame sequencer: sync byte, one read/send pass per register, checksum, done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RDR_IDLE;
      idx       <= '0;
      addr_q    <= '0;
      wcnt      <= '0;
      csum      <= 8'h00;
      hdr_data  <= 8'h00;
      hdr_valid <= 1'b0;
      dump_busy <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      case (state)
        RDR_IDLE: if (dump_start) begin
          idx       <= '0;
          csum      <= 8'h00;
          hdr_data  <= SYNC_BYTE;
          hdr_valid <= 1'b1;
          dump_busy <= 1'b1;
          state     <= RDR_SYNC;
        end
        RDR_SYNC: if (dbg.tx_ready) begin
          hdr_valid <= 1'b0;
          state     <= RDR_ADDR;
        end
        RDR_ADDR: begin
          addr_q <= idx;
          wcnt   <= 2'(READ_LATENCY);
          state  <= RDR_WAIT;
        end
        RDR_WAIT: begin
          if (wcnt == 2'd0) state <= RDR_SEND;
          else              wcnt  <= wcnt - 2'd1;
        end
        RDR_SEND: if (ser_valid && dbg.tx_ready) begin
          csum <= csum ^ ser_byte;
          if (ser_last) begin
            if (idx == ADDR_WIDTH'(NUM_REGS - 1)) begin
              hdr_data  <= csum ^ ser_byte;
              hdr_valid <= 1'b1;
              state     <= RDR_CSUM;
            end else begin
              idx   <= idx + ADDR_WIDTH'(1);
              state <= RDR_ADDR;
            end
          end
        end
        RDR_CSUM: if (dbg.tx_ready) begin
          hdr_valid <= 1'b0;
          dump_done <= 1'b1;
          state     <= RDR_DONE;
        end
        RDR_DONE: begin
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
          state     <= RDR_IDLE;
        end
        default: state <= RDR_IDLE;
      endcase
    end
  end
endmodule
